ula_carregador: RTL and testbench
=================================

# ula_carregador

Sequential operand/operation loader that sits directly upstream of the ALU and also captures its result. The user enters A, B, then mode/opcode on a 6-bit switch bank, confirming each with a button press. The block drives the registered values onto the ALU inputs, samples the ALU's combinational result one cycle later, and holds it for display with a valid flag and an optional timeout.

## Interface
- SHOW_CYCLES, 16: cycles S_SHOW waits for a press before returning to S_A; 0 disables the timeout.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- sw  in  6  entry value (operand, or mode/opcode).
- btn  in  1  debounced, already-synchronous button level; block detects rising edges.
- cancel  in  1  level; abort entry, return to S_A.
- A  out  6  operand A to ALU.
- B  out  6  operand B to ALU.
- selModo  out  1  ALU mode (0 arithmetic, 1 logic).
- selOp  out  3  ALU opcode.
- ula_res  in  7  ALU result.
- ula_co  in  1  ALU carry flag.
- ula_zero  in  1  ALU zero flag.
- res  out  7  captured result.
- co  out  1  captured carry.
- zero  out  1  captured zero.
- res_valid  out  1  res/co/zero hold a live result.
- estado  out  3  current state encoding, for LEDs.

## Operation
- States: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4. Encodings 5–7 are unreachable; if entered, go to S_A next cycle.
- Press = btn==1 && btn_q==0. btn_q is the previous-cycle btn and resets to 0.
- Priority each cycle: reset > cancel > press/timeout.
- S_A: on press, A<=sw, go to S_B.
- S_B: on press, B<=sw, go to S_OP.
- S_OP: on press, selModo<=sw[3], selOp<=sw[2:0], sw[5:4] ignored, go to S_EXEC.
- S_EXEC: lasts exactly one cycle, unconditionally. Capture res<=ula_res, co<=ula_co, zero<=ula_zero, res_valid<=1, go to S_SHOW. A press during S_EXEC is discarded.
- S_SHOW: counter cnt increments each cycle.
  - On press: go to S_A with cnt<=0; res_valid and results stay unchanged.
  - If SHOW_CYCLES!=0, no press, and cnt==SHOW_CYCLES-1: res_valid<=0, go to S_A. res/co/zero keep their values.
- cancel (any state): go to S_A, cnt<=0. A, B, selModo, selOp, res, co, zero and res_valid are unchanged. A press in the same cycle is discarded.
- Outside S_SHOW, cnt holds 0.
- Arithmetic is entirely inside the ALU; this block only does register transfer. cnt is $clog2(SHOW_CYCLES+1) bits wide, minimum 1.

## Timing
- Reset values:
  - State: S_A, estado=0.
  - Outputs: A=0, B=0, selModo=0, selOp=0, res=0, co=0, zero=0, res_valid=0.
  - Internal: btn_q=0, cnt=0.
- A, B, selModo and selOp are registered and change only the cycle after the accepting press.
- Latency: press accepted in S_OP at edge n → selModo/selOp updated and state=S_EXEC after edge n → res/co/zero/res_valid updated after edge n+1.
- A btn held high through reset release produces no press until it falls and rises again.
- Back-to-back presses on consecutive cycles cannot occur, since each needs a low cycle between them. Minimum full sequence is 3 presses + 1 EXEC cycle.
- Timeout fires exactly SHOW_CYCLES cycles after entering S_SHOW.

## Structure
- Package ula_pkg holds:
  - typedef enum logic [2:0] estado_t with S_A..S_SHOW;
  - W_OPER=6 and W_RES=7;
  - named mode constants MODO_ARIT=0 and MODO_LOG=1.
- ula_pkg is shared with the ALU and later stages.
- One sub-module: detecta_borda (clk, reset, in, pulse), the registered rising-edge detector.
- Top level: FSM, data registers and SHOW counter, in one sequential process plus a next-state combinational process.

## Test plan
Bench instantiates ula_carregador connected to the existing ALU.
- Reset with btn held high, release, hold btn 5 cycles → no press; state=S_A, all outputs 0.
- Enter A=5, B=3, sw=6'b000000 (add) → two cycles after the third press: res=8, co=0, zero=0, res_valid=1, estado=4.
- Enter A=63, B=1, add → res=7'b1000000, co=1, zero=0.
- Enter A=5, B=5, sw=6'b000001 (sub) → res=0, zero=1, co=0. Then enter mode 1, op 000 with A=6'h2A, B=6'h0F → res=7'h0A.
- SHOW_CYCLES=4: after a result, no press → res_valid falls and state=S_A exactly 4 cycles after entering S_SHOW; res keeps its value. With SHOW_CYCLES=0 → stays in S_SHOW indefinitely.
- Assert cancel in S_OP together with a press → state=S_A, selOp unchanged, no EXEC. Assert cancel in S_SHOW → state=S_A, res_valid still 1.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the operand loader, the ALU and later stages.
package ula_pkg;

  localparam int W_OPER = 6;
  localparam int W_RES  = 7;

  localparam logic MODO_ARIT = 1'b0;
  localparam logic MODO_LOG  = 1'b1;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } estado_t;

endpackage

// File: rtl/detecta_borda.sv
// Rising-edge detector for an already-synchronous level; a level that is high
// when reset releases must fall before its next rise counts as an edge.
module detecta_borda (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_q;
  logic armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      in_q <= in;
      if (!in) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign pulse = in & ~in_q & armed_q;

endmodule

// File: rtl/ula_carregador.sv
// Loads A, B and mode/opcode from the switch bank, one button press each,
// then captures the ALU result and holds it for display with an optional timeout.
module ula_carregador
  import ula_pkg::*;
#(
  parameter int SHOW_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W_OPER-1:0] sw,
  input  logic              btn,
  input  logic              cancel,
  output logic [W_OPER-1:0] A,
  output logic [W_OPER-1:0] B,
  output logic              selModo,
  output logic [2:0]        selOp,
  input  logic [W_RES-1:0]  ula_res,
  input  logic              ula_co,
  input  logic              ula_zero,
  output logic [W_RES-1:0]  res,
  output logic              co,
  output logic              zero,
  output logic              res_valid,
  output logic [2:0]        estado
);

  localparam int CNT_W = ($clog2(SHOW_CYCLES + 1) < 1) ? 1 : $clog2(SHOW_CYCLES + 1);
  localparam bit TIMEOUT_EN = (SHOW_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SHOW_CYCLES == 0) ? 0 : SHOW_CYCLES - 1);

  estado_t             state_q, state_d;
  logic [W_OPER-1:0]   a_q, a_d, b_q, b_d;
  logic                modo_q, modo_d;
  logic [2:0]          op_q, op_d;
  logic [W_RES-1:0]    res_q, res_d;
  logic                co_q, co_d, zero_q, zero_d, valid_q, valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                press;
  logic                unused_sw;

  // The upper switch bits carry no meaning in the mode/opcode entry.
  assign unused_sw = ^sw[5:4];

  detecta_borda u_borda (
    .clk   (clk),
    .reset (reset),
    .in    (btn),
    .pulse (press)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    modo_d  = modo_q;
    op_d    = op_q;
    res_d   = res_q;
    co_d    = co_q;
    zero_d  = zero_q;
    valid_d = valid_q;
    cnt_d   = '0;
    if (cancel) begin
      state_d = S_A;
    end else begin
      case (state_q)
        S_A: if (press) begin
          a_d     = sw;
          state_d = S_B;
        end
        S_B: if (press) begin
          b_d     = sw;
          state_d = S_OP;
        end
        S_OP: if (press) begin
          modo_d  = sw[3];
          op_d    = sw[2:0];
          state_d = S_EXEC;
        end
        S_EXEC: begin
          res_d   = ula_res;
          co_d    = ula_co;
          zero_d  = ula_zero;
          valid_d = 1'b1;
          state_d = S_SHOW;
        end
        S_SHOW: begin
          if (press) begin
            state_d = S_A;
          end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
            valid_d = 1'b0;
            state_d = S_A;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      modo_q  <= MODO_ARIT;
      op_q    <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      modo_q  <= modo_d;
      op_q    <= op_d;
      res_q   <= res_d;
      co_q    <= co_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign selModo   = modo_q;
  assign selOp     = op_q;
  assign res       = res_q;
  assign co        = co_q;
  assign zero      = zero_q;
  assign res_valid = valid_q;
  assign estado    = state_q;

endmodule

// File: tb/tb_ula_carregador.sv
// Bench for ula_carregador: three instances (timeout 4, disabled, 16) fed the same
// stimulus, each driving a small ALU model, checked every cycle against a reference model.
module tb_ula_carregador;

  localparam int N = 3;

  logic       clk;
  logic       reset;
  logic [5:0] sw;
  logic       btn;
  logic       cancel;

  logic [5:0] a_w     [N];
  logic [5:0] b_w     [N];
  logic       modo_w  [N];
  logic [2:0] op_w    [N];
  logic [6:0] ures_w  [N];
  logic       uco_w   [N];
  logic       uzero_w [N];
  logic [6:0] res_w   [N];
  logic       co_w    [N];
  logic       zero_w  [N];
  logic       valid_w [N];
  logic [2:0] est_w   [N];

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 0;

  // Reference ALU: returns {carry, zero, result}.
  function automatic logic [8:0] alu(input logic [5:0] a, input logic [5:0] b,
                                     input logic m, input logic [2:0] op);
    logic [6:0] r;
    logic       c;
    r = '0;
    c = 1'b0;
    if (!m) begin
      case (op)
        3'd0: begin r = {1'b0, a} + {1'b0, b}; c = r[6]; end
        3'd1: begin r = {1'b0, a} - {1'b0, b}; c = (a < b); end
        default: r = {1'b0, a};
      endcase
    end else begin
      case (op)
        3'd0: r = {1'b0, a & b};
        3'd1: r = {1'b0, a | b};
        3'd2: r = {1'b0, a ^ b};
        default: r = {1'b0, ~a};
      endcase
    end
    return {c, (r == 7'd0), r};
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    assign {uco_w[gi], uzero_w[gi], ures_w[gi]} = alu(a_w[gi], b_w[gi], modo_w[gi], op_w[gi]);
    ula_carregador #(.SHOW_CYCLES(gi == 0 ? 4 : (gi == 1 ? 0 : 16))) dut (
      .clk       (clk),
      .reset     (reset),
      .sw        (sw),
      .btn       (btn),
      .cancel    (cancel),
      .A         (a_w[gi]),
      .B         (b_w[gi]),
      .selModo   (modo_w[gi]),
      .selOp     (op_w[gi]),
      .ula_res   (ures_w[gi]),
      .ula_co    (uco_w[gi]),
      .ula_zero  (uzero_w[gi]),
      .res       (res_w[gi]),
      .co        (co_w[gi]),
      .zero      (zero_w[gi]),
      .res_valid (valid_w[gi]),
      .estado    (est_w[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s inst%0d: got %h expected %h", name, inst, act, exp);
    else n_pass++;
  endtask

  // Reference model: state as a plain number, time spent showing as an unbounded count.
  int         sc        [N] = '{4, 0, 16};
  int         m_state   [N];
  logic [5:0] m_a       [N];
  logic [5:0] m_b       [N];
  logic       m_modo    [N];
  logic [2:0] m_op      [N];
  logic [6:0] m_res     [N];
  logic       m_co      [N];
  logic       m_zero    [N];
  logic       m_valid   [N];
  int         m_elapsed [N];
  bit         prev_btn = 0;
  bit         prev_rst = 1;

  initial begin
    forever begin
      @(posedge clk);
      begin
        bit press;
        logic [8:0] r;
        press = btn && !prev_btn && !prev_rst;
        for (int i = 0; i < N; i++) begin
          if (reset) begin
            m_state[i] = 0; m_a[i] = 0; m_b[i] = 0; m_modo[i] = 0; m_op[i] = 0;
            m_res[i] = 0; m_co[i] = 0; m_zero[i] = 0; m_valid[i] = 0; m_elapsed[i] = 0;
          end else if (cancel) begin
            m_state[i] = 0;
            m_elapsed[i] = 0;
          end else if (m_state[i] == 0 && press) begin
            m_a[i] = sw; m_state[i] = 1;
          end else if (m_state[i] == 1 && press) begin
            m_b[i] = sw; m_state[i] = 2;
          end else if (m_state[i] == 2 && press) begin
            m_modo[i] = sw[3]; m_op[i] = sw[2:0]; m_state[i] = 3;
          end else if (m_state[i] == 3) begin
            r = alu(m_a[i], m_b[i], m_modo[i], m_op[i]);
            {m_co[i], m_zero[i], m_res[i]} = r;
            m_valid[i] = 1; m_state[i] = 4; m_elapsed[i] = 0;
          end else if (m_state[i] == 4) begin
            m_elapsed[i]++;
            if (press) begin
              m_state[i] = 0; m_elapsed[i] = 0;
            end else if (sc[i] != 0 && m_elapsed[i] == sc[i]) begin
              m_valid[i] = 0; m_state[i] = 0; m_elapsed[i] = 0;
            end
          end
        end
        prev_btn = btn;
        prev_rst = reset;
      end
      cmp_en = 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) begin
        chk("cycle", i,
            32'({est_w[i], a_w[i], b_w[i], modo_w[i], op_w[i], res_w[i], co_w[i], zero_w[i], valid_w[i]}),
            32'({3'(m_state[i]), m_a[i], m_b[i], m_modo[i], m_op[i], m_res[i], m_co[i], m_zero[i], m_valid[i]}));
      end
    end
  end

  task automatic press(input logic [5:0] v);
    sw  = v;
    btn = 1'b1;
    @(posedge clk); #1;
    btn = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [5:0] a, input logic [5:0] b, input logic [5:0] m);
    press(a);
    press(b);
    press(m);
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
  endtask

  initial begin
    reset = 1'b1; btn = 1'b1; cancel = 1'b0; sw = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_estado", i, 32'(est_w[i]), 32'd0);
      chk("rst_outs", i, 32'({a_w[i], b_w[i], modo_w[i], op_w[i], res_w[i], co_w[i], zero_w[i], valid_w[i]}), 32'd0);
    end
    btn = 1'b0;
    @(posedge clk); #1;

    do_op(6'd5, 6'd3, 6'b000000);
    chk("add_res", 0, 32'(res_w[0]), 32'd8);
    chk("add_flags", 0, 32'({co_w[0], zero_w[0], valid_w[0]}), 32'b001);
    chk("add_estado", 0, 32'(est_w[0]), 32'd4);
    do_cancel();

    do_op(6'd63, 6'd1, 6'b000000);
    chk("carry_res", 0, 32'(res_w[0]), 32'h40);
    chk("carry_co", 0, 32'({co_w[0], zero_w[0]}), 32'b10);
    do_cancel();

    do_op(6'd5, 6'd5, 6'b000001);
    chk("sub_res", 0, 32'(res_w[0]), 32'd0);
    chk("sub_flags", 0, 32'({co_w[0], zero_w[0]}), 32'b01);
    do_cancel();

    do_op(6'h2A, 6'h0F, 6'b001000);
    chk("and_res", 0, 32'(res_w[0]), 32'h0A);

    repeat (3) @(posedge clk);
    #1 chk("show_hold", 0, 32'({est_w[0], valid_w[0]}), 32'b100_1);
    @(posedge clk);
    #1 chk("timeout", 0, 32'({est_w[0], valid_w[0], res_w[0]}), 32'({3'd0, 1'b0, 7'h0A}));
    chk("no_timeout", 1, 32'({est_w[1], valid_w[1]}), 32'b100_1);
    repeat (20) @(posedge clk);
    #1 chk("no_timeout_long", 1, 32'({est_w[1], valid_w[1]}), 32'b100_1);
    chk("timeout16", 2, 32'({est_w[2], valid_w[2]}), 32'b000_0);
    do_cancel();

    press(6'd1);
    press(6'd2);
    sw = 6'b000111; btn = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    btn = 1'b0; cancel = 1'b0;
    chk("cancel_op_estado", 0, 32'(est_w[0]), 32'd0);
    chk("cancel_op_sel", 0, 32'({modo_w[0], op_w[0]}), 32'b1_000);
    @(posedge clk); #1;
    chk("cancel_no_exec", 0, 32'(est_w[0]), 32'd0);

    do_op(6'd1, 6'd2, 6'b000000);
    chk("pre_cancel_res", 0, 32'(res_w[0]), 32'd3);
    do_cancel();
    chk("cancel_show", 0, 32'({est_w[0], valid_w[0], res_w[0]}), 32'({3'd0, 1'b1, 7'd3}));

    for (int k = 0; k < 1500; k++) begin
      btn    = 1'($urandom_range(0, 1));
      sw     = 6'($urandom);
      cancel = ($urandom_range(0, 29) == 0);
      reset  = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; btn = 1'b0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
